mips32_mem_arbiter: RTL

Single-port memory arbiter for the mips32 pipelined core. It shares one synchronous word-addressed RAM between three requesters: the host/debug port, the MEM-stage data port and the IF-stage fetch port. The host port preloads programs and data and reads back results. The arbiter serialises accesses with a req/ack handshake, applies fixed priority with a fetch anti-starvation override, and hides the RAM read latency from the requesters.

---
 rtl/mips32_mem_pkg.sv | 22 ++
 rtl/mips32_mem_pick.sv | 26 ++
 rtl/mips32_mem_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the mips32 single-port memory arbiter:
// requester IDs, arbiter FSM states and legal RAM latency bounds.
package mips32_mem_pkg;

    typedef enum logic [1:0] {
        ID_HOST  = 2'd0,
        ID_DATA  = 2'd1,
        ID_FETCH = 2'd2,
        ID_NONE  = 2'd3
    } req_id_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;

endpackage

// File: rtl/mips32_mem_pick.sv
// Combinational priority picker: host > data > fetch, except that a
// starved fetch request wins outright.
module mips32_mem_pick
    import mips32_mem_pkg::*;
(
    input  logic    h_req,
    input  logic    d_req,
    input  logic    f_req,
    input  logic    starve,
    output req_id_e winner
);

    always_comb begin
        winner = ID_NONE;
        if (f_req && starve) begin
            winner = ID_FETCH;
        end else if (h_req) begin
            winner = ID_HOST;
        end else if (d_req) begin
            winner = ID_DATA;
        end else if (f_req) begin
            winner = ID_FETCH;
        end
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port RAM arbiter for host, MEM-stage data and IF-stage fetch
// requesters; serialises accesses and hides the RAM read latency.
module mips32_mem_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_ack,
    output logic [DW-1:0] h_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    grant_id
);

    localparam int unsigned SW = $clog2(STARVE_LIM + 1);
    localparam int unsigned LW = $clog2(MEM_LAT_MAX);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
    localparam logic [LW-1:0] LAT_LOAD   = LW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    arb_state_e    state_q, state_d;
    req_id_e       grant_q, grant_d;
    req_id_e       winner;
    logic [SW-1:0] starve_q, starve_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;
    logic          h_ack_q, h_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          f_ack_q, f_ack_d;
    logic [DW-1:0] h_rdata_q, h_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;

    mips32_mem_pick u_pick (
        .h_req  (h_req),
        .d_req  (d_req),
        .f_req  (f_req),
        .starve (starve_q == STARVE_MAX),
        .winner (winner)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        starve_d  = starve_q;
        lat_d     = lat_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        h_rdata_d = h_rdata_q;
        d_rdata_d = d_rdata_q;
        f_rdata_d = f_rdata_q;

        case (state_q)
            IDLE: begin
                grant_d = winner;
                if (winner != ID_NONE) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    case (winner)
                        ID_HOST: begin
                            we_d = h_we; addr_d = h_addr; wdata_d = h_wdata;
                        end
                        ID_DATA: begin
                            we_d = d_we; addr_d = d_addr; wdata_d = d_wdata;
                        end
                        default: begin
                            we_d = 1'b0; addr_d = f_addr;
                        end
                    endcase
                    mem_we_d = we_d;
                    if (winner == ID_FETCH) begin
                        starve_d = '0;
                    end else if (f_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            ISSUE: begin
                if (MEM_LAT == 1) begin
                    state_d = RESP;
                end else begin
                    lat_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = ID_NONE;
                if (!we_q) begin
                    case (grant_q)
                        ID_HOST:  h_rdata_d = mem_rdata;
                        ID_DATA:  d_rdata_d = mem_rdata;
                        ID_FETCH: f_rdata_d = mem_rdata;
                        default:  ;
                    endcase
                end
            end
        endcase

        busy_d  = (state_d != IDLE);
        h_ack_d = (state_d == RESP) && (grant_q == ID_HOST);
        d_ack_d = (state_d == RESP) && (grant_q == ID_DATA);
        f_ack_d = (state_d == RESP) && (grant_q == ID_FETCH);
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= ID_NONE;
            starve_q  <= '0;
            lat_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            h_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            f_ack_q   <= 1'b0;
            h_rdata_q <= '0;
            d_rdata_q <= '0;
            f_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            starve_q  <= starve_d;
            lat_q     <= lat_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            busy_q    <= busy_d;
            h_ack_q   <= h_ack_d;
            d_ack_q   <= d_ack_d;
            f_ack_q   <= f_ack_d;
            h_rdata_q <= h_rdata_d;
            d_rdata_q <= d_rdata_d;
            f_rdata_q <= f_rdata_d;
        end
    end

    // RAM output is itself registered and only valid during the ack cycle,
    // so the owner's rdata forwards it then and holds the captured copy after.
    assign h_rdata   = (h_ack_q && !we_q) ? mem_rdata : h_rdata_q;
    assign d_rdata   = (d_ack_q && !we_q) ? mem_rdata : d_rdata_q;
    assign f_rdata   = (f_ack_q && !we_q) ? mem_rdata : f_rdata_q;
    assign h_ack     = h_ack_q;
    assign d_ack     = d_ack_q;
    assign f_ack     = f_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule
